branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter DATA_W, default 32: PC and target width.
REQ-002 SHALL have parameter ENTRIES, default 16: table entries.
  - Must be a power of 2 and at least 2.
  - IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter TAG_W, default 8: stored tag width.
  - Constraint: IDX_W+TAG_W+2 <= DATA_W.
REQ-004 SHALL have parameter CTR_W, default 2: saturating direction counter width.
REQ-005 SHALL have parameter CNT_W, default 16: misprediction statistics counter width.
REQ-006 SHALL use one clock and an asynchronous, active-low reset. The ports are:
  - clk  in  1  clock; all state changes on the rising edge.
  - arst_n  in  1  asynchronous active-low reset.
  - enable  in  1  global run enable.
  - flush  in  1  invalidate the whole table.
  - lookup_pc  in  DATA_W  PC of the instruction currently being fetched (IF).
  - pred_taken  out  1  predicted taken.
  - pred_next_pc  out  DATA_W  predicted next fetch PC.
  - update_valid  in  1  a resolved branch or jump is presented (MEM).
  - update_pc  in  DATA_W  PC of the resolved instruction.
  - update_taken  in  1  actual outcome.
  - update_target  in  DATA_W  actual target.
  - update_mispred  in  1  the pipeline redirected on this resolution.
  - mispred_count  out  CNT_W  saturating count of mispredictions.

Function
REQ-007 SHALL store per entry: valid (1), tag (TAG_W), target (DATA_W), ctr (CTR_W).
REQ-008 SHALL derive the index and tag of any PC as follows:
  - idx = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
REQ-009 SHALL compute the lookup hit combinationally: hit = valid[idx] and stored tag == tag of lookup_pc.
REQ-010 SHALL drive pred_taken = hit and ctr[CTR_W-1], combinationally with zero-cycle latency.
REQ-011 SHALL drive pred_next_pc as follows; lookup_pc+4 wraps modulo 2^DATA_W.
  - pred_taken=1: stored target.
  - pred_taken=0: lookup_pc+4.
REQ-012 SHALL, when update_valid=1, enable=1, flush=0 and the update PC hits, adjust the entry on the next edge:
  - update_taken=1: ctr saturating increment (stays at 2^CTR_W-1); target <= update_target.
  - update_taken=0: ctr saturating decrement (stays at 0); target unchanged.
REQ-013 SHALL, on an update miss with update_taken=1, allocate the entry:
  - valid <= 1, tag <= update tag, target <= update_target.
  - ctr <= 2^(CTR_W-1) (weakly taken).
  - Any previous occupant is overwritten.
REQ-014 SHALL NOT allocate or modify any entry on an update miss with update_taken=0.
REQ-015 SHALL give a lookup the pre-update table contents when lookup and update address the same index in the same cycle; there is no bypass, and the new state is visible from the next cycle.
REQ-016 SHALL clear all valid bits on the next edge when flush=1 and enable=1.
  - flush has priority over an update in the same cycle; that update is dropped.
  - ctr and target contents are don't-care after a flush.
REQ-017 SHALL increment mispred_count by 1 when update_valid=1, update_mispred=1, enable=1.
  - Saturates at 2^CNT_W-1.
  - Counting is independent of flush.
REQ-018 SHALL freeze all state (table and mispred_count) while enable=0; lookups continue to be answered combinationally.
REQ-019 SHALL ignore update_pc[1:0] and the bits above the tag field.
  - Aliasing PCs share an entry.
  - This aliasing is acceptable behaviour, not an error.

Reset
REQ-020 SHALL clear on arst_n=0, immediately and regardless of clk or enable:
  - all valid bits, all ctr, all target and tag fields, and mispred_count.
REQ-021 SHALL drive these outputs during and after reset until the first allocation:
  - pred_taken=0.
  - pred_next_pc=lookup_pc+4.
  - mispred_count=0.
REQ-022 SHALL apply reset asserted mid-update with priority; the in-flight update is lost.

Verification
REQ-023 Cold lookup: reset, then lookup_pc=0x0000_0040 -> pred_taken=0, pred_next_pc=0x0000_0044.
REQ-024 Allocate and train:
  - update 0x40 taken to target 0x100 -> next cycle lookup 0x40 gives pred_taken=1, pred_next_pc=0x100 (ctr=2).
  - Second taken update -> ctr=3.
  - Two not-taken updates -> ctr=1, pred_taken=0, pred_next_pc=0x44.
REQ-025 Alias/tag conflict, default parameters:
  - 0x40 allocated; lookup 0x440 (same idx, different tag) -> miss, pred_next_pc=0x444.
  - Taken update at 0x440 to 0x200 replaces the entry, after which lookup 0x40 misses.
REQ-026 Simultaneous events:
  - Same-cycle lookup/update on 0x40 returns the old prediction.
  - flush plus a taken update in one cycle leaves the table empty.
  - enable=0 with updates leaves ctr and mispred_count unchanged.
REQ-027 Counter saturation: CNT_W=4, 20 mispredicting updates -> mispred_count=15.
  - Then arst_n pulsed low mid-cycle -> mispred_count=0 and pred_taken=0 immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational; training, allocation, flush and miss statistics update on the clock edge.
module branch_predictor #(
  parameter int DATA_W  = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic [DATA_W-1:0] lookup_pc,
  output logic              pred_taken,
  output logic [DATA_W-1:0] pred_next_pc,
  input  logic              update_valid,
  input  logic [DATA_W-1:0] update_pc,
  input  logic              update_taken,
  input  logic [DATA_W-1:0] update_target,
  input  logic              update_mispred,
  output logic [CNT_W-1:0]  mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [DATA_W-1:0]  r_target [ENTRIES];
  logic [CTR_W-1:0]   r_ctr    [ENTRIES];
  logic [CNT_W-1:0]   r_mispred_cnt;

  logic [IDX_W-1:0] w_lkp_idx;
  logic [TAG_W-1:0] w_lkp_tag;
  logic             w_lkp_hit;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic [CTR_W-1:0] w_upd_ctr;
  logic [CTR_W-1:0] w_ctr_next;
  logic             w_upd_en;

  // Bits [1:0] and everything above the tag field are ignored, so aliasing PCs share an entry.
  assign w_lkp_idx = lookup_pc[IDX_W+1:2];
  assign w_lkp_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_upd_idx = update_pc[IDX_W+1:2];
  assign w_upd_tag = update_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign w_lkp_hit    = r_valid[w_lkp_idx] && (r_tag[w_lkp_idx] == w_lkp_tag);
  assign pred_taken   = w_lkp_hit && r_ctr[w_lkp_idx][CTR_W-1];
  assign pred_next_pc = pred_taken ? r_target[w_lkp_idx] : lookup_pc + DATA_W'(4);

  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_upd_ctr = r_ctr[w_upd_idx];
  assign w_upd_en  = enable && !flush && update_valid;

  assign w_ctr_next = update_taken ? ((w_upd_ctr == CTR_MAX)  ? w_upd_ctr : w_upd_ctr + CTR_W'(1))
                                   : ((w_upd_ctr == CTR_ZERO) ? w_upd_ctr : w_upd_ctr - CTR_W'(1));

  // Table state: flush wins over a same-cycle update; not-taken misses never allocate.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_valid <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= {TAG_W{1'b0}};
        r_target[i] <= {DATA_W{1'b0}};
        r_ctr[i]    <= CTR_ZERO;
      end
    end else if (enable && flush) begin
      r_valid <= {ENTRIES{1'b0}};
    end else if (w_upd_en) begin
      if (w_upd_hit) begin
        r_ctr[w_upd_idx] <= w_ctr_next;
        if (update_taken) begin
          r_target[w_upd_idx] <= update_target;
        end else begin
          r_target[w_upd_idx] <= r_target[w_upd_idx];
        end
      end else if (update_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= update_target;
        r_ctr[w_upd_idx]    <= CTR_WEAK;
      end else begin
        r_valid <= r_valid;
      end
    end else begin
      r_valid <= r_valid;
    end
  end

  // Saturating misprediction statistics, counted regardless of flush.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_mispred_cnt <= {CNT_W{1'b0}};
    end else if (enable && update_valid && update_mispred && (r_mispred_cnt != CNT_MAX)) begin
      r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
    end else begin
      r_mispred_cnt <= r_mispred_cnt;
    end
  end

  assign mispred_count = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (CNT_W=4 so counter saturation is reachable).
module tb_branch_predictor;

  logic        clk;
  logic        arst_n;
  logic        enable;
  logic        flush;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispred;
  logic [3:0]  mispred_count;

  int checks_r;
  int errors_r;
  int exp_cnt_r;

  branch_predictor #(.DATA_W(32), .ENTRIES(16), .TAG_W(8), .CTR_W(2), .CNT_W(4)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .flush(flush),
    .lookup_pc(lookup_pc), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispred(update_mispred),
    .mispred_count(mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic look(input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_pc,
                      input string tag);
    lookup_pc = pc;
    #1;
    check_eq({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
    check_eq({tag, "_next"}, pred_next_pc, exp_pc);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic mis);
    update_valid   = 1'b1;
    update_pc      = pc;
    update_taken   = taken;
    update_target  = tgt;
    update_mispred = mis;
    @(posedge clk);
    #1;
    update_valid   = 1'b0;
    update_mispred = 1'b0;
    if (mis && enable && exp_cnt_r < 15) exp_cnt_r++;
  endtask

  initial begin
    checks_r = 0; errors_r = 0; exp_cnt_r = 0;
    arst_n = 1'b0; enable = 1'b1; flush = 1'b0;
    lookup_pc = 32'h40; update_valid = 1'b0; update_pc = 32'h0;
    update_taken = 1'b0; update_target = 32'h0; update_mispred = 1'b0;
    #2;
    look(32'h40, 1'b0, 32'h44, "rst_cold");
    check_eq("rst_cnt", {28'd0, mispred_count}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    arst_n = 1'b1;
    look(32'h40, 1'b0, 32'h44, "cold");

    // Allocate: same-cycle lookup still sees the old (empty) entry
    update_valid = 1'b1; update_pc = 32'h40; update_taken = 1'b1;
    update_target = 32'h100; update_mispred = 1'b1;
    look(32'h40, 1'b0, 32'h44, "same_cycle");
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    look(32'h40, 1'b1, 32'h100, "alloc");
    check_eq("cnt_1", {28'd0, mispred_count}, exp_cnt_r);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40, 1'b1, 32'h100, "ctr_top_sat");
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40, 1'b0, 32'h44, "ctr_1");
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b1, 32'h120, 1'b0);
    look(32'h40, 1'b0, 32'h44, "ctr_bot_sat");
    upd(32'h40, 1'b1, 32'h140, 1'b0);
    look(32'h40, 1'b1, 32'h140, "retarget");

    // Tag conflict at the same index
    look(32'h440, 1'b0, 32'h444, "alias_miss");
    upd(32'h440, 1'b1, 32'h200, 1'b1);
    look(32'h440, 1'b1, 32'h200, "replace");
    look(32'h40, 1'b0, 32'h44, "evicted");
    look(32'h4442, 1'b1, 32'h200, "ignored_bits");

    // Not-taken miss must not allocate
    upd(32'h80, 1'b0, 32'h300, 1'b0);
    look(32'h80, 1'b0, 32'h84, "nt_no_alloc");

    // Flush beats a same-cycle taken update; the mispredict still counts
    flush = 1'b1;
    upd(32'h80, 1'b1, 32'h300, 1'b1);
    flush = 1'b0;
    look(32'h80, 1'b0, 32'h84, "flush_drop");
    look(32'h440, 1'b0, 32'h444, "flush_clear");
    check_eq("cnt_flush", {28'd0, mispred_count}, exp_cnt_r);

    // Freeze while disabled
    upd(32'h440, 1'b1, 32'h200, 1'b0);
    enable = 1'b0;
    upd(32'h440, 1'b0, 32'h0, 1'b1);
    upd(32'h440, 1'b0, 32'h0, 1'b1);
    flush = 1'b1;
    upd(32'h440, 1'b0, 32'h0, 1'b1);
    flush = 1'b0;
    look(32'h440, 1'b1, 32'h200, "frozen");
    check_eq("cnt_frozen", {28'd0, mispred_count}, exp_cnt_r);
    enable = 1'b1;

    // Saturate the statistics counter
    for (int i = 0; i < 20; i++) upd(32'h80, 1'b0, 32'h0, 1'b1);
    check_eq("cnt_sat", {28'd0, mispred_count}, 32'd15);
    look(32'hFFFF_FFFC, 1'b0, 32'h0, "pc_wrap");

    // Reset mid-cycle with an update in flight
    update_valid = 1'b1; update_pc = 32'h80; update_taken = 1'b1;
    update_target = 32'h500; update_mispred = 1'b1;
    #2;
    arst_n = 1'b0;
    look(32'h440, 1'b0, 32'h444, "rst_mid");
    check_eq("rst_mid_cnt", {28'd0, mispred_count}, 32'd0);
    @(posedge clk); #3;
    update_valid = 1'b0; update_mispred = 1'b0;
    arst_n = 1'b1;
    look(32'h80, 1'b0, 32'h84, "rst_drop");
    check_eq("rst_after_cnt", {28'd0, mispred_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
